// File: rtl/seq_bit_serializer_pkg.sv
// seq_pkg: shared state encoding, default idle level and counter width helper for the serializer.
package seq_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  localparam logic IDLE_BIT_DEF = 1'b1;
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/seq_bit_serializer_if.sv
// seq_bit_serializer_if: word handshake in, serial bit stream out towards the sequence detector.
interface seq_bit_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic x;
  logic x_valid;
  logic last;
  logic busy;
  modport master (output din, din_valid, input din_ready, x, x_valid, last, busy);
  modport slave (input din, din_valid, output din_ready, x, x_valid, last, busy);
endinterface

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial stage feeding a serial sequence detector.
// Define SEQ_SER_PARITY_EN to append an even-parity bit after each word.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter logic IDLE_BIT  = IDLE_BIT_DEF,
  parameter bit   MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  seq_bit_serializer_if.slave s
);
  localparam int CW = cnt_w(WIDTH);
`ifdef SEQ_SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  state_t state_q;
  logic [WIDTH-1:0] sh_q, sh_d, ld_d;
  logic [CW-1:0] cnt_q;
  logic x_q, xv_q, last_q, busy_q;
  logic end_slot, accept, first_bit, next_bit;
`ifdef SEQ_SER_PARITY_EN
  logic par_q;
  assign end_slot = state_q == PARITY;
`else
  assign end_slot = state_q == SHIFT && last_q;
`endif
  // sh_q holds only the bits not yet sent, with the next one at the outgoing end
  assign ld_d = MSB_FIRST ? s.din << 1 : s.din >> 1;
  assign sh_d = MSB_FIRST ? sh_q << 1 : sh_q >> 1;
  assign first_bit = MSB_FIRST ? s.din[WIDTH-1] : s.din[0];
  assign next_bit = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
  assign s.din_ready = rst && (state_q == IDLE || end_slot);
  assign accept = s.din_valid && s.din_ready;
  assign s.x = x_q;
  assign s.x_valid = xv_q;
  assign s.last = last_q;
  assign s.busy = busy_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      cnt_q <= '0;
      x_q <= IDLE_BIT;
      xv_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
      par_q <= 1'b0;
`endif
    end else if (accept) begin
      state_q <= SHIFT;
      sh_q <= ld_d;
      cnt_q <= CW'(WIDTH - 1);
      x_q <= first_bit;
      xv_q <= 1'b1;
      last_q <= 1'b0;
      busy_q <= 1'b1;
`ifdef SEQ_SER_PARITY_EN
      par_q <= ^s.din;
`endif
    end else if (state_q == SHIFT && cnt_q != '0) begin
      sh_q <= sh_d;
      cnt_q <= cnt_q - 1'b1;
      x_q <= next_bit;
      last_q <= !PAR && cnt_q == CW'(1);
`ifdef SEQ_SER_PARITY_EN
    end else if (state_q == SHIFT) begin
      state_q <= PARITY;
      x_q <= par_q;
      last_q <= 1'b1;
`endif
    end else begin
      state_q <= IDLE;
      x_q <= IDLE_BIT;
      xv_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: table vectors, reset corner cases and random traffic against a bit-queue model.
module tb_seq_bit_serializer;
  localparam int W = 4;
`ifdef SEQ_SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] din = '0;
  logic dv = 1'b0;
  always #5 clk = ~clk;
  seq_bit_serializer_if #(.WIDTH(W)) a ();
  seq_bit_serializer_if #(.WIDTH(W)) b ();
  assign a.din = din;
  assign a.din_valid = dv;
  assign b.din = din;
  assign b.din_valid = dv;
  seq_bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b1), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rst(rst), .s(a));
  seq_bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b1), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst(rst), .s(b));
  typedef struct {logic x; logic l;} bit_t;
  typedef struct {logic v; logic [W-1:0] d; logic [4:0] e;} vec_t;
  bit_t q0[$];
  bit_t q1[$];
  vec_t tbl[14];
  int total = 0;
  int bad = 0;
  task automatic chk(input string n, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: {x,x_valid,last,busy,din_ready} got %b want %b at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [4:0] expect_of(input bit_t q[$]);
    if (q.size() == 0) return 5'b10001;
    return {q[0].x, 1'b1, q[0].l, 1'b1, q[0].l};
  endfunction
  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      q0.push_back('{w[W-1-i], !PAR && i == W - 1});
      q1.push_back('{w[i], !PAR && i == W - 1});
    end
    if (PAR) begin
      q0.push_back('{^w, 1'b1});
      q1.push_back('{^w, 1'b1});
    end
  endtask
  task automatic check_model(input string n);
    chk({n, "_msb"}, {a.x, a.x_valid, a.last, a.busy, a.din_ready}, expect_of(q0));
    chk({n, "_lsb"}, {b.x, b.x_valid, b.last, b.busy, b.din_ready}, expect_of(q1));
  endtask
  task automatic step(input logic v, input logic [W-1:0] d, input string n);
    logic acc;
    dv = v;
    din = d;
    acc = v && (q0.size() == 0 || q0[0].l);
    @(posedge clk);
    #1;
    if (q0.size() != 0) void'(q0.pop_front());
    if (q1.size() != 0) void'(q1.pop_front());
    if (acc) push_word(d);
    check_model(n);
  endtask
  initial begin
`ifdef SEQ_SER_PARITY_EN
    tbl = '{'{1, 4'b0111, 5'b01010}, '{0, 4'b0111, 5'b11010}, '{0, 4'b0000, 5'b11010},
            '{0, 4'b0000, 5'b11010}, '{0, 4'b0000, 5'b11111}, '{0, 4'b0000, 5'b10001},
            '{1, 4'b0011, 5'b01010}, '{0, 4'b0000, 5'b01010}, '{0, 4'b0000, 5'b11010},
            '{0, 4'b0000, 5'b11010}, '{0, 4'b0000, 5'b01111}, '{0, 4'b0000, 5'b10001},
            '{0, 4'b0000, 5'b10001}, '{0, 4'b0000, 5'b10001}};
`else
    tbl = '{'{1, 4'b0011, 5'b01010}, '{0, 4'b0011, 5'b01010}, '{0, 4'b0000, 5'b11010},
            '{0, 4'b0000, 5'b11111}, '{0, 4'b0000, 5'b10001}, '{1, 4'b1100, 5'b11010},
            '{1, 4'b1100, 5'b11010}, '{1, 4'b1100, 5'b01010}, '{1, 4'b0011, 5'b01111},
            '{1, 4'b0011, 5'b01010}, '{0, 4'b0000, 5'b01010}, '{0, 4'b0000, 5'b11010},
            '{0, 4'b0000, 5'b11111}, '{0, 4'b0000, 5'b10001}};
`endif
    repeat (2) @(posedge clk);
    #1;
    dv = 1'b1;
    #1;
    chk("reset_msb", {a.x, a.x_valid, a.last, a.busy, a.din_ready}, 5'b10000);
    chk("reset_lsb", {b.x, b.x_valid, b.last, b.busy, b.din_ready}, 5'b10000);
    dv = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_model("release");
    for (int i = 0; i < 20; i++) step(1'b0, '0, "idle");
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v, tbl[i].d, "tbl_model");
      chk($sformatf("tbl_%0d", i), {a.x, a.x_valid, a.last, a.busy, a.din_ready}, tbl[i].e);
    end
    step(1'b1, 4'b1010, "abort_w");
    step(1'b0, '0, "abort_w");
    #2;
    rst = 1'b0;
    #1;
    chk("abort_msb", {a.x, a.x_valid, a.last, a.busy, a.din_ready}, 5'b10000);
    chk("abort_lsb", {b.x, b.x_valid, b.last, b.busy, b.din_ready}, 5'b10000);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 4'b1010, "restart");
    chk("restart_first", {a.x, a.x_valid, a.busy}, {1'b1, 1'b1, 1'b1});
    for (int i = 0; i < W + 1; i++) step(1'b0, '0, "restart");
    for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0, W'($urandom), "rand");
    for (int i = 0; i < W + 2; i++) step(1'b0, '0, "drain");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the serial sequence detectors (0011 and others).
- Accepts WIDTH-bit words through a valid/ready handshake and emits them one bit per clock on x, which drives the detector's x input.
- Between words, x holds a defined idle level so the downstream detector sees a deterministic stream.

Parameters:
- WIDTH, default 8: data bits per word; must be at least 2.
- IDLE_BIT, default 1'b1: level driven on x when no bit is being sent. The default of 1 prevents spurious leading zeros into the 0011 detector.
- MSB_FIRST, default 1: 1 sends din[WIDTH-1] first; 0 sends din[0] first.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- din  input  WIDTH  parallel word to send
- din_valid  input  1  din holds a word
- din_ready  output  1  block can accept a word this cycle
- x  output  1  serial bit to the detector
- x_valid  output  1  x carries a data (or parity) bit this cycle
- last  output  1  x carries the final bit of the current word
- busy  output  1  a word is in flight

Behaviour:
- Reset (rst=0, asynchronous) sets x=IDLE_BIT, x_valid=0, last=0, busy=0 and state=IDLE, and clears the shift register and bit counter.
  - din_ready is forced to 0 while rst=0.
  - Reset during a word aborts it immediately; no remaining bits are sent.
- States: IDLE, SHIFT, plus PARITY when the optional feature is compiled in.
- Output timing: x, x_valid and last are registered.
- Handshake: a word is accepted on a rising edge where din_valid=1 and din_ready=1.
  - din_ready is combinational: 1 in IDLE, and 1 in SHIFT during the final bit (last=1 without parity). It is 0 otherwise.
  - din must be held stable until accepted.
- Latency: for a word accepted at edge N, its first bit appears on x with x_valid=1 in the cycle following edge N. It remains for one cycle per bit.
- IDLE -> SHIFT on accept.
  - The shift register loads din.
  - bit_cnt loads WIDTH-1.
  - busy goes to 1.
- SHIFT advances one bit per clock.
  - bit_cnt decrements.
  - last=1 when bit_cnt=0.
- At bit_cnt=0:
  - If a new word is accepted on the same edge, the next word's first bit follows with no bubble and the state stays SHIFT.
  - Otherwise the state goes to IDLE, x returns to IDLE_BIT, and x_valid=0.
- Ordering: MSB_FIRST=1 shifts left and sends bit WIDTH-1 down to bit 0. MSB_FIRST=0 sends bit 0 up to bit WIDTH-1.
- bit_cnt width is $clog2(WIDTH); there is no wrap-around beyond 0.
- din_valid arriving while not ready is ignored, not queued.
- busy=1 from the accept edge until the edge that ends the final bit, unless a back-to-back accept occurs on that edge.

Optional Feature:
- Macro: SEQ_SER_PARITY_EN.
- When defined:
  - After the WIDTH data bits, the PARITY state sends one extra bit equal to the XOR of the accepted word (even parity), with x_valid=1.
  - last is asserted on the parity bit, not on the final data bit.
  - din_ready's back-to-back slot moves to the parity cycle.
  - Each word occupies WIDTH+1 cycles.
- When undefined: the PARITY state, the parity register and the parity logic are absent, and each word occupies exactly WIDTH cycles.

Decomposition:
- Shared package seq_pkg holds:
  - the state typedef (IDLE, SHIFT, PARITY);
  - the localparam for the default IDLE_BIT;
  - a function computing the counter width.
- Single flat module; no sub-module is needed. Shift register, counter and FSM fit in about 150 lines.

Test Plan:
- Single word (WIDTH=4, MSB_FIRST=1): din=4'b0011 accepted at edge 1 -> x=0,0,1,1 in cycles 2-5, x_valid=1, last=1 in cycle 5 only, then x=1, x_valid=0. With the 0011 detector attached, its y output pulses.
- Back-to-back: 4'b1100 then 4'b0011 with din_valid held -> eight consecutive x_valid=1 cycles carrying 1,1,0,0,0,0,1,1, with din_ready=1 only at idle and on each last cycle.
- Idle: din_valid=0 for 20 cycles after reset -> x=1, x_valid=0, busy=0 and din_ready=1 throughout.
- Reset mid-word: pull rst low after 2 of 4 bits of 4'b1010 -> x=1, x_valid=0, busy=0 immediately (asynchronous). A word applied after release restarts from its first bit.
- LSB-first: MSB_FIRST=0, din=4'b0011 -> x=1,1,0,0.
- Parity (SEQ_SER_PARITY_EN defined, WIDTH=4): din=4'b0111 -> x=0,1,1,1,1 with last on the fifth bit. din=4'b0011 -> x=0,0,1,1,0.
